// File: rtl/cordic_argred.sv
// cordic_argred
// Argument reduction and sign correction in front of a CORDIC cosine core.
// Folds a Q3.13 angle in [-4,4) rad into [-pi/2,pi/2], hands the reduced
// angle (Q2.14) to the core, waits for its result and negates it when the
// fold moved the angle by pi (cos(x -/+ pi) = -cos(x)).
//
// Ports:
//   clk, rst_b      clock, async active-low reset
//   req, ang        start request and Q3.13 angle (sampled while rdy=1)
//   rdy             high in IDLE only
//   done, cos_out   one-cycle completion pulse, Q2.14 cosine (held)
//   theta, bgn      reduced angle and one-cycle start pulse to the core
//   fin, cos_in     core completion flag and its Q2.14 cosine
module cordic_argred #(
  parameter logic [15:0] PI  = 16'h6488,
  parameter logic [15:0] HPI = 16'h3244
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req,
  input  logic [15:0] ang,
  output logic        rdy,
  output logic        done,
  output logic [15:0] cos_out,
  output logic [15:0] theta,
  output logic        bgn,
  input  logic        fin,
  input  logic [15:0] cos_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_REDUCE, S_START, S_WAIT, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [15:0] a;
  logic        neg;

  // fold arithmetic, 17 bits so a - PI / a + PI cannot overflow
  logic signed [16:0] a17, pi17, hpi17, r;
  logic               fold_neg;

  assign a17   = {a[15], a};
  assign pi17  = {PI[15], PI};
  assign hpi17 = {HPI[15], HPI};

  always_comb begin
    r        = a17;
    fold_neg = 1'b0;
    if (a17 > hpi17) begin
      r        = a17 - pi17;
      fold_neg = 1'b1;
    end else if (a17 < -hpi17) begin
      r        = a17 + pi17;
      fold_neg = 1'b1;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req) state_nxt = S_REDUCE;
      S_REDUCE: state_nxt = S_START;
      S_START:  state_nxt = S_WAIT;
      S_WAIT:   if (fin) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // outputs decoded from state only
  always_comb begin
    rdy  = (state == S_IDLE);
    bgn  = (state == S_START);
    done = (state == S_DONE);
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      a       <= '0;
      neg     <= 1'b0;
      theta   <= '0;
      cos_out <= '0;
    end else begin
      if (state == S_IDLE && req)
        a <= ang;
      if (state == S_REDUCE) begin
        neg   <= fold_neg;
        // r is within [-pi/2,pi/2] here, so dropping the top bits of
        // the Q3.13 -> Q2.14 shift loses nothing
        theta <= 16'(r << 1);
      end
      if (state == S_WAIT && fin)
        cos_out <= neg ? 16'(16'd0 - cos_in) : cos_in;
    end
  end

endmodule
